// File: rtl/panel_scan.sv
// Reader side of the 32x32 LED panel framebuffer: scans a double-buffered RGB444
// image and drives the panel shift/latch/blank/row lines with 4-bit binary-coded modulation.
module panel_scan #(
  parameter int DISP_BASE = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] rd_addr,
  input  logic [11:0] rd_data,
  input  logic        buffer_select,
  output logic        buffer_current,
  output logic        r0,
  output logic        g0,
  output logic        b0,
  output logic        r1,
  output logic        g1,
  output logic        b1,
  output logic [3:0]  a,
  output logic        blank,
  output logic        latch,
  output logic        sclk
);

  // ST_INIT only exists for the single cycle after reset; it starts the first shift
  // exactly like UNBLANK would, but keeps the LEDs dark.
  localparam logic [2:0] ST_INIT    = 3'd0;
  localparam logic [2:0] ST_SHIFT   = 3'd1;
  localparam logic [2:0] ST_BLANK   = 3'd2;
  localparam logic [2:0] ST_LATCH1  = 3'd3;
  localparam logic [2:0] ST_LATCH2  = 3'd4;
  localparam logic [2:0] ST_UNBLANK = 3'd5;

  localparam logic [15:0] BASE = 16'(DISP_BASE);

  logic [2:0]  state;
  logic [3:0]  row;
  logic [1:0]  plane;
  logic        bank;
  logic [15:0] disp_cnt;

  logic        busy;
  logic [6:0]  cyc;
  logic [2:0]  top_bits;

  logic [3:0]  red;
  logic [3:0]  grn;
  logic [3:0]  blu;
  logic        shift_done;
  logic        start_shift;
  logic        frame_start;

  assign red = rd_data[11:8];
  assign grn = rd_data[7:4];
  assign blu = rd_data[3:0];

  assign shift_done  = !busy || (cyc == 7'd127);
  assign start_shift = (state == ST_INIT) || (state == ST_UNBLANK);
  assign frame_start = (state == ST_INIT) ||
                       ((state == ST_UNBLANK) && (row == 4'd15) && (plane == 2'd3));

  // cyc[1:0] is the column phase; phase 1 reads the bottom-half row (row + 16).
  assign rd_addr = {bank, (cyc[1:0] == 2'd1), row, cyc[6:2]};

  assign buffer_current = bank;
  assign latch = (state == ST_LATCH1) || (state == ST_LATCH2);
  assign blank = !((state == ST_UNBLANK) ||
                   ((state == ST_SHIFT) && (disp_cnt != 16'd0)));

  // The display counter is loaded on the edge into UNBLANK so it is already
  // holding the full on-time during that cycle; blank lifts for exactly that many cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      row      <= 4'd0;
      plane    <= 2'd0;
      bank     <= 1'b0;
      a        <= 4'd0;
      disp_cnt <= 16'd0;
    end else begin
      if (disp_cnt != 16'd0) begin
        disp_cnt <= disp_cnt - 16'd1;
      end
      case (state)
        ST_INIT: begin
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (shift_done && (disp_cnt == 16'd0)) begin
            state <= ST_BLANK;
          end
        end
        ST_BLANK: begin
          state <= ST_LATCH1;
        end
        ST_LATCH1: begin
          state <= ST_LATCH2;
          a     <= row;
        end
        ST_LATCH2: begin
          state    <= ST_UNBLANK;
          disp_cnt <= BASE << plane;
        end
        ST_UNBLANK: begin
          state <= ST_SHIFT;
          plane <= plane + 2'd1;
          if (plane == 2'd3) begin
            row <= row + 4'd1;
          end
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
      if (frame_start) begin
        bank <= buffer_select;
      end
    end
  end

  // Column pipeline: address top in phase 0, bottom in phase 1, capture each a cycle
  // later; data updates after phase 2 and sclk rises one full cycle after that.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      cyc      <= 7'd0;
      top_bits <= 3'd0;
      r0       <= 1'b0;
      g0       <= 1'b0;
      b0       <= 1'b0;
      r1       <= 1'b0;
      g1       <= 1'b0;
      b1       <= 1'b0;
      sclk     <= 1'b0;
    end else begin
      sclk <= busy && (cyc[1:0] == 2'd3);
      if (start_shift) begin
        busy <= 1'b1;
        cyc  <= 7'd0;
      end else if (busy) begin
        cyc <= cyc + 7'd1;
        if (cyc == 7'd127) begin
          busy <= 1'b0;
        end
      end
      if (busy && (cyc[1:0] == 2'd1)) begin
        top_bits <= {red[plane], grn[plane], blu[plane]};
      end
      if (busy && (cyc[1:0] == 2'd2)) begin
        {r0, g0, b0} <= top_bits;
        {r1, g1, b1} <= {red[plane], grn[plane], blu[plane]};
      end
    end
  end

endmodule

// File: tb/tb_panel_scan.sv
// Directed bench for panel_scan: a framebuffer RAM model plus a negedge monitor that
// records shifted bits, latch times, row addresses and on-times for the checks below.
module tb_panel_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] rd_addr;
  logic [11:0] rd_data;
  logic        buffer_select = 1'b0;
  logic        buffer_current;
  logic        r0, g0, b0, r1, g1, b1;
  logic [3:0]  a;
  logic        blank, latch, sclk;

  int vectors = 0;
  int miscompares = 0;
  int cyc_count = 0;

  logic [11:0] mem [0:2047];

  typedef struct {
    int          cyc;
    int          sclks;
    logic [31:0] r0v, g0v, b0v, r1v, g1v, b1v, bankv;
  } rec_t;

  rec_t rec_q[$];
  int   a_q[$];
  int   dur_q[$];

  int          sclk_cnt;
  logic [31:0] r0v, g0v, b0v, r1v, g1v, b1v, bankv;
  logic        prev_sclk, prev_latch, prev_blank;
  int          on_cnt;

  int          rel, rel2, nrec, row_e, pl_e, per_e;
  logic        bk_e;
  logic [3:0]  g_nib, b_nib;

  panel_scan #(.DISP_BASE(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .buffer_select  (buffer_select),
    .buffer_current (buffer_current),
    .r0             (r0),
    .g0             (g0),
    .b0             (b0),
    .r1             (r1),
    .g1             (g1),
    .b1             (b1),
    .a              (a),
    .blank          (blank),
    .latch          (latch),
    .sclk           (sclk)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_count <= cyc_count + 1;

  always @(posedge clk) rd_data <= mem[rd_addr];

  always @(negedge clk) begin
    if (rst) begin
      sclk_cnt   <= 0;
      r0v <= '0; g0v <= '0; b0v <= '0; r1v <= '0; g1v <= '0; b1v <= '0; bankv <= '0;
      prev_sclk  <= 1'b0;
      prev_latch <= 1'b0;
      prev_blank <= 1'b1;
      on_cnt     <= 0;
    end else begin
      prev_sclk  <= sclk;
      prev_latch <= latch;
      prev_blank <= blank;
      if (sclk && !prev_sclk) begin
        if (sclk_cnt < 32) begin
          r0v[sclk_cnt[4:0]]   <= r0;
          g0v[sclk_cnt[4:0]]   <= g0;
          b0v[sclk_cnt[4:0]]   <= b0;
          r1v[sclk_cnt[4:0]]   <= r1;
          g1v[sclk_cnt[4:0]]   <= g1;
          b1v[sclk_cnt[4:0]]   <= b1;
          bankv[sclk_cnt[4:0]] <= rd_addr[10];
        end
        sclk_cnt <= sclk_cnt + 1;
      end
      if (latch && !prev_latch) begin
        rec_q.push_back('{cyc_count, sclk_cnt, r0v, g0v, b0v, r1v, g1v, b1v, bankv});
        sclk_cnt <= 0;
        r0v <= '0; g0v <= '0; b0v <= '0; r1v <= '0; g1v <= '0; b1v <= '0; bankv <= '0;
      end
      if (!blank && prev_blank) a_q.push_back(int'(a));
      if (blank && !prev_blank) begin
        dur_q.push_back(on_cnt);
        on_cnt <= 0;
      end else if (!blank) begin
        on_cnt <= on_cnt + 1;
      end
    end
  end

  task automatic applyStimulus(input logic rst_v, input logic sel_v);
    rst = rst_v;
    buffer_select = sel_v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_blank"}, 32'(blank), 32'd1);
    checkOutput({tag, "_latch"}, 32'(latch), 32'd0);
    checkOutput({tag, "_sclk"}, 32'(sclk), 32'd0);
    checkOutput({tag, "_a"}, 32'(a), 32'd0);
    checkOutput({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    checkOutput({tag, "_rgb"}, 32'({r0, g0, b0, r1, g1, b1}), 32'd0);
    checkOutput({tag, "_buffer_current"}, 32'(buffer_current), 32'd0);
  endtask

  task automatic waitLatches(input int n);
    int budget;
    budget = 800 * (n - rec_q.size()) + 400;
    while (rec_q.size() < n && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1;
    if (rec_q.size() < n) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL wait_latches: observed %0d latches, expected %0d", rec_q.size(), n);
    end
  endtask

  task automatic waitBlankLow();
    int budget;
    budget = 400;
    while (blank !== 1'b0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (blank !== 1'b0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL wait_unblank: observed blank %b, expected 0 within budget", blank);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 12'h000;
    mem[11'h000] = 12'hF00;
    mem[{1'b0, 5'd17, 5'd5}] = 12'h0A5;
    mem[11'h400] = 12'h00F;
    g_nib = 4'hA;
    b_nib = 4'h5;

    #1 applyStimulus(1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1 checkResetOutputs("por");

    @(posedge clk);
    #1 applyStimulus(1'b0, 1'b0);
    rel = cyc_count;
    @(posedge clk);
    @(posedge clk);
    #1 checkOutput("rd_addr_bottom_c0", 32'(rd_addr), 32'h200);

    waitLatches(21);
    applyStimulus(1'b0, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("bc_hold", 32'(buffer_current), 32'd0);
    checkOutput("bank_hold", 32'(rd_addr[10]), 32'd0);

    waitLatches(64);
    checkOutput("bc_before_wrap", 32'(buffer_current), 32'd0);
    waitBlankLow();
    @(posedge clk);
    #1;
    checkOutput("bc_after_wrap", 32'(buffer_current), 32'd1);
    checkOutput("rd_addr_after_wrap", 32'(rd_addr), 32'h400);

    waitLatches(70);

    for (int k = 0; k < 70 && k < rec_q.size(); k++) begin
      row_e = (k / 4) % 16;
      pl_e  = k % 4;
      bk_e  = (k >= 64);
      checkOutput($sformatf("sclks[%0d]", k), 32'(rec_q[k].sclks), 32'd32);
      checkOutput($sformatf("r0[%0d]", k), rec_q[k].r0v,
                  (!bk_e && row_e == 0) ? 32'h1 : 32'h0);
      checkOutput($sformatf("g0[%0d]", k), rec_q[k].g0v, 32'h0);
      checkOutput($sformatf("b0[%0d]", k), rec_q[k].b0v,
                  (bk_e && row_e == 0) ? 32'h1 : 32'h0);
      checkOutput($sformatf("r1[%0d]", k), rec_q[k].r1v, 32'h0);
      checkOutput($sformatf("g1[%0d]", k), rec_q[k].g1v,
                  (!bk_e && row_e == 1 && g_nib[pl_e]) ? 32'h20 : 32'h0);
      checkOutput($sformatf("b1[%0d]", k), rec_q[k].b1v,
                  (!bk_e && row_e == 1 && b_nib[pl_e]) ? 32'h20 : 32'h0);
      checkOutput($sformatf("bank[%0d]", k), rec_q[k].bankv,
                  bk_e ? 32'hFFFF_FFFF : 32'h0);
    end

    if (rec_q.size() > 0)
      checkOutput("first_latch_cycle", 32'(rec_q[0].cyc - rel), 32'd130);

    for (int k = 0; k < 69 && k + 1 < rec_q.size(); k++) begin
      pl_e  = k % 4;
      per_e = ((32 << pl_e) > 128 ? (32 << pl_e) : 128) + 4;
      checkOutput($sformatf("latch_spacing[%0d]", k),
                  32'(rec_q[k + 1].cyc - rec_q[k].cyc), 32'(per_e));
    end

    for (int k = 0; k < 66 && k < dur_q.size(); k++)
      checkOutput($sformatf("on_time[%0d]", k), 32'(dur_q[k]), 32'(32 << (k % 4)));

    for (int k = 0; k < 69 && k < a_q.size(); k++)
      checkOutput($sformatf("row_addr[%0d]", k), 32'(a_q[k]), 32'((k / 4) % 16));

    repeat (50) @(posedge clk);
    #3 applyStimulus(1'b1, 1'b1);
    #1 checkResetOutputs("mid");

    repeat (3) @(posedge clk);
    #1 applyStimulus(1'b0, 1'b1);
    rel2 = cyc_count;
    nrec = rec_q.size();
    waitLatches(nrec + 1);
    if (rec_q.size() > nrec) begin
      checkOutput("restart_latch_cycle", 32'(rec_q[nrec].cyc - rel2), 32'd130);
      checkOutput("restart_bank", rec_q[nrec].bankv, 32'hFFFF_FFFF);
      checkOutput("restart_b0", rec_q[nrec].b0v, 32'h1);
      checkOutput("restart_r0", rec_q[nrec].r0v, 32'h0);
    end
    checkOutput("restart_bc", 32'(buffer_current), 32'd1);
    waitBlankLow();
    checkOutput("restart_a", 32'(a), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/panel_scan.md
# panel_scan

Reader side of the 32x32 LED panel framebuffer. It scans a double-buffered 12-bit RGB444 framebuffer through a synchronous read port and drives the panel's shift, latch, blank and row-address lines with 4-bit binary-coded modulation. It sits in the panel clock domain behind the dual-port framebuffer RAM that the GPMC register block writes. The currently displayed bank is reported back so the write side can swap buffers tear-free.

## Interface
- DISP_BASE, 32: display time of bit plane 0 in clk cycles; plane p is displayed for DISP_BASE<<p cycles; legal range 1..4095.
- clk  input  1  panel scan clock (10 MHz in the system).
- rst  input  1  asynchronous reset, active-high.
- rd_addr  output  11  framebuffer read address: [10] = bank, [9:5] = row 0..31, [4:0] = column 0..31.
- rd_data  input  12  framebuffer read data; valid the cycle after rd_addr is presented. Bits [11:8] = R, [7:4] = G, [3:0] = B.
- buffer_select  input  1  requested display bank; already synchronised to clk.
- buffer_current  output  1  bank the current frame is read from.
- r0, g0, b0  output  1 each  serial colour bits for the top half (rows 0..15).
- r1, g1, b1  output  1 each  serial colour bits for the bottom half (rows 16..31).
- a  output  4  row-pair address of the latched data.
- blank  output  1  high = LEDs off.
- latch  output  1  high = transfer shift register to output latches.
- sclk  output  1  shift clock; the panel samples data on the rising edge.

## Operation
- Reset: blank=1; latch=0; sclk=0; r0..b1=0; a=0; rd_addr=0; buffer_current=0.
  - Internal state: row=0, plane=0, display counter=0, shifter starts column 0 on the first clk after rst falls.
- Scan order: for row r = 0..15, planes 0..3; frame = 64 shift/latch periods, then wrap to row 0, plane 0.
- Shifter, per column c (4 cycles):
  - C0: rd_addr = {bank, r, c}.
  - C1: rd_addr = {bank, r+16, c}; capture top pixel bit p of R/G/B.
  - C2: capture bottom bit; drive r0,g0,b0,r1,g1,b1 from the captured bits; sclk=0.
  - C3: sclk=1.
  - 32 columns = 128 cycles, then sclk returns to 0 and the shifter reports done.
- Display counter: loaded with DISP_BASE<<plane_latched at UNBLANK, decrements to 0 while blank=0.
- Latch sequencer states: SHIFT, BLANK, LATCH1, LATCH2, UNBLANK.
  - SHIFT -> BLANK: when shift is done AND the display counter = 0.
  - BLANK: blank=1 (1 cycle).
  - LATCH1, LATCH2: latch=1, blank=1; a <= row just shifted (updated in LATCH1).
  - UNBLANK: latch=0, blank=0; load the display counter for the plane just latched; advance plane (and row/frame on wrap); start the next shift in the same cycle.
- Shifting of the next plane overlaps display of the current plane.
- Bank selection: buffer_select is sampled only in the UNBLANK that starts the shift of row 0, plane 0 (and once after reset).
  - The sampled value drives rd_addr[10] and buffer_current for the whole frame.
  - buffer_select changes at any other time have no effect until the next frame start.
- Counter widths: the display counter is 16 bits (4095<<3 fits). Row and plane counters wrap naturally (4-bit and 2-bit).

## Timing
- Read latency is fixed at 1 cycle; rd_data is not sampled in any cycle other than C1/C2.
- Data is set up ≥1 cycle before the sclk rising edge and held 1 cycle after it (changes in the next C2).
- Plane period = max(128, DISP_BASE<<p) + 4 cycles (BLANK + LATCH1 + LATCH2 + UNBLANK). With DISP_BASE=32: 132, 132, 132, 260.
- First latch after reset: rst falls at cycle 0, shift runs cycles 1..128, BLANK at 129, latch=1 at 130..131, blank=0 at 132.
- Reset mid-operation: all outputs return to reset values asynchronously, and the scan restarts at row 0, plane 0 with a fresh bank sample.

## Test plan
- Reset values: assert rst mid-shift -> blank=1, latch=0, sclk=0, a=0, rd_addr=0, rgb=0 immediately. First latch pulse 130 cycles after release.
- Single pixel: bank0 addr 0x000=0xF00, all others 0 -> for row-pair 0, planes 0..3, r0=1 only at column 0. r1, g, b always 0; exactly 32 sclk rising edges per latch.
- Bit planes: pixel at row 17, column 5 = 0x0A5 -> bottom half, column 5. g1 pattern over planes 0..3 = 0,1,0,1; b1 pattern = 1,0,1,0.
- Plane timing: DISP_BASE=32 -> blank=0 durations 32, 64, 128, 256 cycles. Latch spacing 132, 132, 132, 260.
- Buffer swap: toggle buffer_select to 1 mid-frame -> rd_addr[10] and buffer_current stay 0 until the row 0/plane 0 UNBLANK, then switch to 1 there.
- Wrap: run 64 periods -> a sequence is 0,0,0,0,1,...,15, and the frame returns to a=0 with plane 0.
